// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA output path: pixel layout, mux states,
// and the per-channel fade scaler.
package vga_pkg;

    localparam int SYNC_DELAY_DEFAULT = 3;

    typedef logic [3:0] channel_t;

    typedef struct packed {
        channel_t r;
        channel_t g;
        channel_t b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_FADE = 2'd1,
        ST_OVER = 2'd2
    } mux_state_t;

    // Scales a nibble by (level+1)/16; the 8-bit product keeps bits [7:4].
    function automatic channel_t scale_channel(input channel_t c, input logic [3:0] level);
        logic [7:0] product;
        product = {4'd0, c} * ({4'd0, level} + 8'd1);
        return product[7:4];
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a reset value, used to line timing signals up
// with the draw pipeline.
module sync_delay_line #(
    parameter int               DEPTH       = 3,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             system_clock_in,
    input  logic             system_reset_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge system_clock_in) begin
        if (system_reset_in) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VALUE;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_output_mux.sv
// Final VGA stage: sync alignment, blanking and game / game-over picture selection.
// Define VGA_OUTPUT_MUX_FADE_EN to build in the frame-by-frame fade before game-over.
//
// state | meaning
// PLAY  | game picture, waiting for a latched game_over
// FADE  | game picture dimmed one level per frame
// OVER  | game-over picture, waiting for a latched restart
module vga_output_mux
    import vga_pkg::*;
#(
    parameter int SYNC_DELAY  = SYNC_DELAY_DEFAULT,
    parameter int FADE_FRAMES = 16
) (
    input  logic        system_clock_in,
    input  logic        system_reset_in,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [11:0] game_rgb,
    input  logic [11:0] gameover_rgb,
    input  logic        game_over,
    input  logic        restart,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_tick,
    output logic        showing_gameover,
    output logic [3:0]  fade_level
);

    localparam logic [3:0] LEVEL_FULL = 4'hF;
    localparam logic [3:0] FADE_LOAD  = 4'(FADE_FRAMES - 1);

    logic       d_hs;
    logic       d_vs;
    logic       d_blank;
    mux_state_t state;
    mux_state_t state_next;
    logic       pending_over;
    logic       pending_over_next;
    logic       pending_restart;
    logic       pending_restart_next;
    pixel_t     pix_game;
    pixel_t     pix_over;
    pixel_t     pix_sel;

    sync_delay_line #(
        .DEPTH       (SYNC_DELAY),
        .WIDTH       (3),
        .RESET_VALUE (3'b111)
    ) u_sync_delay (
        .system_clock_in (system_clock_in),
        .system_reset_in (system_reset_in),
        .din             ({hsync, vsync, blank}),
        .dout            ({d_hs, d_vs, d_blank})
    );

    // vga_vs is d_vs one cycle later, so this marks the cycle vga_vs first reads low.
    always_ff @(posedge system_clock_in) begin
        if (system_reset_in) begin
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vga_hs     <= d_hs;
            vga_vs     <= d_vs;
            frame_tick <= vga_vs & ~d_vs;
        end
    end

    assign pix_game = pixel_t'(game_rgb);
    assign pix_over = pixel_t'(gameover_rgb);

    always_ff @(posedge system_clock_in) begin
        if (system_reset_in) begin
            state           <= ST_PLAY;
            pending_over    <= 1'b0;
            pending_restart <= 1'b0;
        end else begin
            state           <= state_next;
            pending_over    <= pending_over_next;
            pending_restart <= pending_restart_next;
        end
    end

`ifdef VGA_OUTPUT_MUX_FADE_EN
    logic [3:0] fade_cnt;
    logic [3:0] fade_cnt_next;

    always_ff @(posedge system_clock_in) begin
        if (system_reset_in) fade_cnt <= LEVEL_FULL;
        else                 fade_cnt <= fade_cnt_next;
    end

    assign fade_level = fade_cnt;
`else
    // Without the fade the level is pinned at full; FADE_FRAMES has no effect.
    assign fade_level = LEVEL_FULL | FADE_LOAD;
`endif

    always_comb begin
        state_next           = state;
        pending_over_next    = pending_over;
        pending_restart_next = pending_restart;
        pix_sel              = pix_game;
`ifdef VGA_OUTPUT_MUX_FADE_EN
        fade_cnt_next        = fade_cnt;
`endif
        case (state)
            ST_PLAY: begin
                if (game_over) pending_over_next = 1'b1;
                if (frame_tick && pending_over) begin
`ifdef VGA_OUTPUT_MUX_FADE_EN
                    state_next    = ST_FADE;
                    fade_cnt_next = FADE_LOAD;
`else
                    state_next    = ST_OVER;
`endif
                end
            end
`ifdef VGA_OUTPUT_MUX_FADE_EN
            ST_FADE: begin
                pix_sel.r = scale_channel(pix_game.r, fade_cnt);
                pix_sel.g = scale_channel(pix_game.g, fade_cnt);
                pix_sel.b = scale_channel(pix_game.b, fade_cnt);
                if (frame_tick) begin
                    if (fade_cnt == 4'd0) state_next    = ST_OVER;
                    else                  fade_cnt_next = fade_cnt - 4'd1;
                end
            end
`endif
            ST_OVER: begin
                pix_sel = pix_over;
                if (frame_tick && pending_restart) begin
                    state_next           = ST_PLAY;
                    pending_over_next    = 1'b0;
                    pending_restart_next = 1'b0;
`ifdef VGA_OUTPUT_MUX_FADE_EN
                    fade_cnt_next        = LEVEL_FULL;
`endif
                end else if (restart) begin
                    pending_restart_next = 1'b1;
                end
            end
            default: state_next = ST_PLAY;
        endcase
    end

    assign showing_gameover = (state == ST_OVER);

    always_ff @(posedge system_clock_in) begin
        if (system_reset_in || d_blank) {vga_r, vga_g, vga_b} <= 12'h000;
        else                            {vga_r, vga_g, vga_b} <= pix_sel;
    end

endmodule

// File: tb/tb_vga_output_mux.sv
// Directed bench for vga_output_mux: a frame-level reference model checked every
// cycle, plus hand-computed spot values at the interesting cycles.
module tb_vga_output_mux;

    localparam int NCYC   = 1400;
    localparam int FP     = 40;
    localparam int FADE_N = 16;
    localparam int M_PLAY = 0;
    localparam int M_FADE = 1;
    localparam int M_OVER = 2;

    logic        system_clock_in = 1'b0;
    logic        system_reset_in;
    logic        hsync, vsync, blank;
    logic [11:0] game_rgb, gameover_rgb;
    logic        game_over, restart;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;
    logic        frame_tick, showing_gameover;
    logic [3:0]  fade_level;

    int errors = 0;
    int checks = 0;

    // Inputs applied during each cycle, and the expected vga_vs / frame_tick per cycle.
    logic        h_rst  [NCYC];
    logic        h_hs   [NCYC];
    logic        h_vs   [NCYC];
    logic        h_bl   [NCYC];
    logic        h_go   [NCYC];
    logic        h_rs   [NCYC];
    logic [11:0] h_game [NCYC];
    logic [11:0] h_over [NCYC];
    logic        e_vs_a [NCYC];
    logic        e_ft_a [NCYC];

    vga_output_mux #(
        .SYNC_DELAY  (3),
        .FADE_FRAMES (FADE_N)
    ) dut (
        .system_clock_in  (system_clock_in),
        .system_reset_in  (system_reset_in),
        .hsync            (hsync),
        .vsync            (vsync),
        .blank            (blank),
        .game_rgb         (game_rgb),
        .gameover_rgb     (gameover_rgb),
        .game_over        (game_over),
        .restart          (restart),
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .vga_hs           (vga_hs),
        .vga_vs           (vga_vs),
        .frame_tick       (frame_tick),
        .showing_gameover (showing_gameover),
        .fade_level       (fade_level)
    );

    always #5 system_clock_in = ~system_clock_in;

    task automatic chk(input string name, input int c, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, exp);
        end
    endtask

    // True when the input from k cycles ago reached the output with no reset in between.
    function automatic bit path_clean(input int c, input int k);
        if (c - k < 0) return 1'b0;
        for (int j = c - k; j < c; j++) if (h_rst[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [11:0] model_pixel(input int mode, input int lvl,
                                                input logic [11:0] game, input logic [11:0] over);
        int r, g, b;
        if (mode == M_OVER) return over;
        if (mode == M_PLAY) return game;
        r = (int'(game[11:8]) * (lvl + 1)) / 16;
        g = (int'(game[7:4])  * (lvl + 1)) / 16;
        b = (int'(game[3:0])  * (lvl + 1)) / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    initial begin
        int          m_mode, m_lvl, pos, e_lvl;
        bit          m_po, m_pr, tick;
        logic        e_hs, e_bl_d, e_show;
        logic [11:0] e_rgb;

        system_reset_in = 1'b1;
        hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        game_rgb = 12'h000; gameover_rgb = 12'h35A;
        game_over = 1'b0; restart = 1'b0;
        m_mode = M_PLAY; m_lvl = 15; m_po = 1'b0; m_pr = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge system_clock_in);

            // Model: outputs of cycle c from inputs of earlier cycles.
            e_hs      = path_clean(c, 4) ? h_hs[c-4] : 1'b1;
            e_vs_a[c] = path_clean(c, 4) ? h_vs[c-4] : 1'b1;
            e_ft_a[c] = (c >= 1) && e_vs_a[c-1] && !e_vs_a[c];
            e_bl_d    = path_clean(c - 1, 3) ? h_bl[c-4] : 1'b1;
            if (!path_clean(c, 1) || e_bl_d) e_rgb = 12'h000;
            else e_rgb = model_pixel(m_mode, m_lvl, h_game[c-1], h_over[c-1]);

            if (c == 0 || h_rst[c-1]) begin
                m_mode = M_PLAY; m_lvl = 15; m_po = 1'b0; m_pr = 1'b0;
            end else begin
                tick = e_ft_a[c-1];
                case (m_mode)
                    M_PLAY: begin
                        if (tick && m_po) begin
`ifdef VGA_OUTPUT_MUX_FADE_EN
                            m_mode = M_FADE; m_lvl = FADE_N - 1;
`else
                            m_mode = M_OVER;
`endif
                        end
                        if (h_go[c-1]) m_po = 1'b1;
                    end
                    M_FADE: if (tick) begin
                        if (m_lvl == 0) m_mode = M_OVER;
                        else m_lvl = m_lvl - 1;
                    end
                    default: begin
                        if (tick && m_pr) begin
                            m_mode = M_PLAY; m_po = 1'b0; m_pr = 1'b0; m_lvl = 15;
                        end else if (h_rs[c-1]) m_pr = 1'b1;
                    end
                endcase
            end
            e_show = (m_mode == M_OVER);
`ifdef VGA_OUTPUT_MUX_FADE_EN
            e_lvl = (m_mode == M_PLAY) ? 15 : (m_mode == M_OVER) ? 0 : m_lvl;
`else
            e_lvl = 15;
`endif

            chk("vga_hs", c, {11'd0, vga_hs}, {11'd0, e_hs});
            chk("vga_vs", c, {11'd0, vga_vs}, {11'd0, e_vs_a[c]});
            chk("frame_tick", c, {11'd0, frame_tick}, {11'd0, e_ft_a[c]});
            chk("rgb", c, {vga_r, vga_g, vga_b}, e_rgb);
            chk("showing_gameover", c, {11'd0, showing_gameover}, {11'd0, e_show});
            chk("fade_level", c, {8'd0, fade_level}, 12'(e_lvl));

            // Hand-computed spot values.
            case (c)
                3, 1301: begin
                    chk("rst_rgb", c, {vga_r, vga_g, vga_b}, 12'h000);
                    chk("rst_hs_vs", c, {10'd0, vga_hs, vga_vs}, 12'h003);
                    chk("rst_level", c, {8'd0, fade_level}, 12'h00F);
                    chk("rst_show", c, {11'd0, showing_gameover}, 12'h000);
                end
                103, 105: chk("hs_around_pulse", c, {11'd0, vga_hs}, 12'h001);
                104:      chk("hs_pulse", c, {11'd0, vga_hs}, 12'h000);
                126:      chk("blank_forces_zero", c, {vga_r, vga_g, vga_b}, 12'h000);
                151:      chk("rgb_latency", c, {vga_r, vga_g, vga_b}, 12'hABC);
                208, 210: chk("no_tick", c, {11'd0, frame_tick}, 12'h000);
                209:      chk("tick", c, {11'd0, frame_tick}, 12'h001);
`ifdef VGA_OUTPUT_MUX_FADE_EN
                260: begin
                    chk("fade15_rgb", c, {vga_r, vga_g, vga_b}, 12'hF80);
                    chk("fade15_level", c, {8'd0, fade_level}, 12'h00F);
                end
                590: begin
                    chk("fade7_rgb", c, {vga_r, vga_g, vga_b}, 12'h740);
                    chk("fade7_level", c, {8'd0, fade_level}, 12'h007);
                end
                889:  chk("fade0_show", c, {11'd0, showing_gameover}, 12'h000);
                890:  chk("over_show", c, {11'd0, showing_gameover}, 12'h001);
                900:  chk("over_rgb", c, {vga_r, vga_g, vga_b}, 12'h35A);
                930, 969: chk("over_held", c, {11'd0, showing_gameover}, 12'h001);
                970:  chk("restart_play", c, {7'd0, showing_gameover, fade_level}, 12'h00F);
                980:  chk("play_rgb", c, {vga_r, vga_g, vga_b}, 12'hF80);
                1295: chk("coincident_fade9", c, {8'd0, fade_level}, 12'h009);
`else
                243:  chk("play_rgb", c, {vga_r, vga_g, vga_b}, 12'hF80);
                249, 410, 969: chk("not_over", c, {11'd0, showing_gameover}, 12'h000);
                250, 409, 970, 1020: chk("over", c, {11'd0, showing_gameover}, 12'h001);
                260: begin
                    chk("direct_over_rgb", c, {vga_r, vga_g, vga_b}, 12'h35A);
                    chk("direct_over_level", c, {8'd0, fade_level}, 12'h00F);
                end
`endif
                default: ;
            endcase

            // Drive this cycle's inputs.
            pos             = c % FP;
            system_reset_in = (c <= 2) || (c == 1300);
            vsync           = !((pos == 5) || (pos == 6));
            hsync           = !((pos == 38) || (c == 100));
            blank           = (pos < 10);
            game_rgb        = (c == 150) ? 12'hABC : (c == 125) ? 12'hFFF : 12'hF80;
            gameover_rgb    = 12'h35A;
            game_over       = (c == 215) || (c == 940) || (c == 1009);
            restart         = (c == 400) || (c == 935);

            h_rst[c] = system_reset_in; h_hs[c] = hsync; h_vs[c] = vsync; h_bl[c] = blank;
            h_go[c] = game_over; h_rs[c] = restart; h_game[c] = game_rgb; h_over[c] = gameover_rgb;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_output_mux.md
VGA_OUTPUT_MUX -- requirements
Module: vga_output_mux

Interface
REQ-001 SHALL have parameter SYNC_DELAY, default 3, cycles from timing-generator outputs to valid rgb from the draw stages.
REQ-002 SHALL have parameter FADE_FRAMES, default 16, number of fade frames; power of two, at most 16.
REQ-003 SHALL have port system_clock_in, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port system_reset_in, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports hsync and vsync, inputs, 1 bit each, undelayed active-low syncs from the timing generator.
REQ-006 SHALL have port blank, input, 1 bit, undelayed blanking; 1 means outside the visible area.
REQ-007 SHALL have ports game_rgb and gameover_rgb, inputs, 12 bits each, {R,G,B} nibbles already SYNC_DELAY cycles late.
REQ-008 SHALL have ports game_over and restart, inputs, 1 bit each, single-cycle request pulses.
REQ-009 SHALL have ports vga_r, vga_g and vga_b, outputs, 4 bits each, registered pixel colour.
REQ-010 SHALL have ports vga_hs and vga_vs, outputs, 1 bit each, registered delayed syncs.
REQ-011 SHALL have ports frame_tick (1 bit), showing_gameover (1 bit) and fade_level (4 bits), outputs: one-cycle frame pulse, state flag, current fade level.

Function
REQ-012 SHALL delay hsync, vsync and blank by SYNC_DELAY cycles; output register adds 1, so vga_hs(t+SYNC_DELAY+1)=hsync(t).
REQ-013 SHALL make colour outputs 1 cycle after game_rgb/gameover_rgb and aligned with vga_hs/vga_vs.
REQ-014 SHALL force {vga_r,vga_g,vga_b}=0 whenever delayed blank=1, in every state.
REQ-015 SHALL pulse frame_tick for exactly one cycle when delayed vsync goes 1->0.
REQ-016 SHALL implement FSM states PLAY, FADE and OVER.
REQ-017 SHALL in PLAY output game_rgb and latch a game_over pulse into pending_over.
REQ-018 SHALL move PLAY->FADE on the first frame_tick with pending_over set, loading fade_level=FADE_FRAMES-1.
REQ-019 SHALL in FADE output each channel c as (c*(fade_level+1))>>4, using an 8-bit product and bits [7:4].
REQ-020 SHALL in FADE decrement fade_level by 1 per frame_tick, and at a frame_tick with fade_level=0 move to OVER.
REQ-021 SHALL in OVER output gameover_rgb, assert showing_gameover, and latch a restart pulse into pending_restart.
REQ-022 SHALL move OVER->PLAY on the first frame_tick with pending_restart set, clearing pending_restart and pending_over.
REQ-023 SHALL drop restart during PLAY or FADE and game_over during FADE or OVER, with no effect.
REQ-024 SHALL on coincident request and frame_tick in the same cycle latch the request and act on the next frame_tick, never the current one.
REQ-025 SHALL hold fade_level at 15 in PLAY and at 0 in OVER.
REQ-026 SHALL change state only on frame_tick, so no frame mixes states.

Reset
REQ-027 SHALL on system_reset_in=1 at a clock edge set: state PLAY, pending flags 0, fade_level 15, colour outputs 0, vga_hs/vga_vs 1, delay-line syncs 1, delay-line blank 1, frame_tick 0.
REQ-028 SHALL let reset mid-FADE or mid-OVER return to PLAY on the same edge, taking precedence over all other inputs.

Configuration
REQ-029 SHALL honour macro VGA_OUTPUT_MUX_FADE_EN: when defined, behaviour is as above.
REQ-030 SHALL when VGA_OUTPUT_MUX_FADE_EN is undefined compile out FADE and the multiplier, go PLAY->OVER directly on the qualifying frame_tick, and tie fade_level to 15.

Structure
REQ-031 SHALL take the state enum, the rgb channel/pixel typedefs and the SYNC_DELAY default from shared package vga_pkg.
REQ-032 SHALL use one sub-module, sync_delay_line: a parameterised-depth, parameterised-width shift register with reset value, used for {hsync,vsync,blank}.

Verification
REQ-033 SHALL check latency: single-cycle hsync low at cycle 100 -> vga_hs low at cycle 104 only; game_rgb=12'hABC with blank=0 -> vga_r/g/b=A/B/C one cycle later.
REQ-034 SHALL check blanking: delayed blank=1 with game_rgb=12'hFFF -> colour outputs 0.
REQ-035 SHALL check fade: game_over mid-frame, game_rgb=12'hF80 -> next frame_tick enters FADE at level 15 showing F/8/0; level 7 shows 7/4/0; after 16 fade frames OVER, showing_gameover=1.
REQ-036 SHALL check restart: in OVER, restart pulse -> PLAY at next frame_tick; game_over in the same OVER frame is ignored; restart during FADE is ignored.
REQ-037 SHALL check reset mid-fade at level 9 -> next cycle PLAY, fade_level 15, outputs 0, vga_hs/vga_vs 1.
REQ-038 SHALL check the macro undefined: game_over -> OVER at the first frame_tick, with no intermediate colours.
